// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and instruction field positions for the multicycle ARM controller.
package cpu_ctrl_pkg;

   localparam int unsigned INSTR_W  = 32;
   localparam int unsigned WAIT_W   = 8;
   localparam int unsigned CLS_HI   = 27;
   localparam int unsigned CLS_LO   = 25;
   localparam int unsigned OPC_HI   = 24;
   localparam int unsigned BIT_LINK = 24;
   localparam int unsigned BIT_L    = 20;
   localparam int unsigned BIT_S    = 20;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      CLS_DP  = 2'd0,
      CLS_SDT = 2'd1,
      CLS_BR  = 2'd2,
      CLS_NOP = 2'd3
   } iclass_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_LINK = 2'd2
   } wb_sel_e;

   typedef struct packed {
      iclass_e cls;
      logic    is_compare;
      logic    is_load;
      logic    is_link;
   } instr_info_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface multicycle_controller_if #(
   parameter int unsigned CNT_W = 16
);
   import cpu_ctrl_pkg::*;

   logic               stall;
   logic [INSTR_W-1:0] instr;
   logic               cond_pass;
   logic               imem_ready;
   logic               dmem_ready;
   logic               imem_req;
   logic               dmem_req;
   logic               dmem_we;
   logic               fetch_en;
   logic               regfetch_en;
   logic               execute_en;
   logic               pc_en;
   logic               pc_branch;
   logic               cpsr_write;
   logic               reg_write;
   logic [1:0]         wb_sel;
   logic [2:0]         state;
   logic               fault;
   logic [CNT_W-1:0]   retired;

   modport master (
      input  stall, instr, cond_pass, imem_ready, dmem_ready,
      output imem_req, dmem_req, dmem_we, fetch_en, regfetch_en, execute_en,
             pc_en, pc_branch, cpsr_write, reg_write, wb_sel, state, fault, retired
   );

   modport slave (
      output stall, instr, cond_pass, imem_ready, dmem_ready,
      input  imem_req, dmem_req, dmem_we, fetch_en, regfetch_en, execute_en,
             pc_en, pc_branch, cpsr_write, reg_write, wb_sel, state, fault, retired
   );

endinterface

// File: rtl/instr_classifier.sv
// Combinational decode of the instruction word into class and the flags the sequencer needs.
module instr_classifier
   import cpu_ctrl_pkg::*;
(
   input  logic [INSTR_W-1:0] instr_i,
   output instr_info_t        info_c_o
);

   logic [2:0] cls_field;
   iclass_e    cls;
   logic       unused_instr_bits;

   assign unused_instr_bits = ^{instr_i[31:28], instr_i[19:0]};

   always_comb begin
      cls_field = instr_i[CLS_HI:CLS_LO];
      casez (cls_field)
         3'b00?:  cls = CLS_DP;
         3'b01?:  cls = CLS_SDT;
         3'b101:  cls = CLS_BR;
         default: cls = CLS_NOP;
      endcase
      info_c_o.cls        = cls;
      // TST/TEQ/CMP/CMN only when S is set; the S=0 encodings are not flag-only ops
      info_c_o.is_compare = (cls == CLS_DP) && (instr_i[OPC_HI -: 2] == 2'b10) && instr_i[BIT_S];
      info_c_o.is_load    = (cls == CLS_SDT) && instr_i[BIT_L];
      info_c_o.is_link    = (cls == CLS_BR) && instr_i[BIT_LINK];
   end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multicycle datapath. Every strobe is the registered action of the
// state just evaluated, so it appears on the cycle after the decision that produced it.
module multicycle_controller
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input logic                     clk,
   input logic                     nreset,
   multicycle_controller_if.master bus
);

   instr_info_t       info;

   state_e            state_q,       state_d;
   logic [WAIT_W-1:0] wait_q,        wait_d;
   logic              fault_q,       fault_d;
   logic [CNT_W-1:0]  retired_q,     retired_d;
   logic              imem_req_q,    imem_req_d;
   logic              dmem_req_q,    dmem_req_d;
   logic              dmem_we_q,     dmem_we_d;
   wb_sel_e           wb_sel_q,      wb_sel_d;
   logic              fetch_en_q,    fetch_en_d;
   logic              regfetch_en_q, regfetch_en_d;
   logic              execute_en_q,  execute_en_d;
   logic              pc_en_q,       pc_en_d;
   logic              pc_branch_q,   pc_branch_d;
   logic              cpsr_write_q,  cpsr_write_d;
   logic              reg_write_q,   reg_write_d;

   logic              waiting;
   logic              expire;
   logic              retire;

   instr_classifier u_classifier (
      .instr_i  (bus.instr),
      .info_c_o (info)
   );

   // Next-state and action decode; a stalled cycle holds everything and emits no strobes.
   always_comb begin
      state_d       = state_q;
      wait_d        = wait_q;
      fault_d       = fault_q;
      retired_d     = retired_q;
      imem_req_d    = imem_req_q;
      dmem_req_d    = dmem_req_q;
      dmem_we_d     = dmem_we_q;
      wb_sel_d      = wb_sel_q;
      fetch_en_d    = 1'b0;
      regfetch_en_d = 1'b0;
      execute_en_d  = 1'b0;
      pc_en_d       = 1'b0;
      pc_branch_d   = 1'b0;
      cpsr_write_d  = 1'b0;
      reg_write_d   = 1'b0;
      waiting       = 1'b0;
      expire        = 1'b0;
      retire        = 1'b0;

      if (!bus.stall) begin
         case (state_q)
            ST_FETCH: begin
               if (imem_req_q && bus.imem_ready) begin
                  fetch_en_d = 1'b1;
                  state_d    = ST_DECODE;
               end else begin
                  waiting = imem_req_q;
               end
            end
            ST_DECODE: begin
               regfetch_en_d = 1'b1;
               state_d       = ST_EXECUTE;
            end
            ST_EXECUTE: begin
               execute_en_d = 1'b1;
               if (!bus.cond_pass || info.cls == CLS_NOP) begin
                  pc_en_d = 1'b1;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  case (info.cls)
                     CLS_DP: begin
                        cpsr_write_d = bus.instr[BIT_S];
                        if (info.is_compare) begin
                           pc_en_d = 1'b1;
                           retire  = 1'b1;
                           state_d = ST_FETCH;
                        end else begin
                           wb_sel_d = WB_ALU;
                           state_d  = ST_WRITEBACK;
                        end
                     end
                     CLS_BR: begin
                        pc_en_d     = 1'b1;
                        pc_branch_d = 1'b1;
                        if (info.is_link) begin
                           wb_sel_d = WB_LINK;
                           state_d  = ST_WRITEBACK;
                        end else begin
                           retire  = 1'b1;
                           state_d = ST_FETCH;
                        end
                     end
                     default: state_d = ST_MEMORY;
                  endcase
               end
            end
            ST_MEMORY: begin
               if (dmem_req_q && bus.dmem_ready) begin
                  if (info.is_load) begin
                     wb_sel_d = WB_MEM;
                     state_d  = ST_WRITEBACK;
                  end else begin
                     pc_en_d = 1'b1;
                     retire  = 1'b1;
                     state_d = ST_FETCH;
                  end
               end else begin
                  waiting = dmem_req_q;
               end
            end
            ST_WRITEBACK: begin
               reg_write_d = 1'b1;
               pc_en_d     = (info.cls != CLS_BR);
               retire      = 1'b1;
               state_d     = ST_FETCH;
            end
            default: state_d = ST_FETCH;
         endcase

         // An unanswered request that hits the limit skips the instruction without retiring it.
         expire = waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
         if (expire) begin
            fault_d = 1'b1;
            pc_en_d = 1'b1;
            state_d = ST_FETCH;
         end
         wait_d     = (waiting && !expire) ? wait_q + WAIT_W'(1) : '0;
         imem_req_d = (state_d == ST_FETCH) && !expire;
         dmem_req_d = (state_d == ST_MEMORY);
         dmem_we_d  = dmem_req_d && !info.is_load;
         if (retire) begin
            retired_d = retired_q + CNT_W'(1);
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (nreset) begin
         state_q       <= ST_FETCH;
         wait_q        <= '0;
         fault_q       <= 1'b0;
         retired_q     <= '0;
         imem_req_q    <= 1'b0;
         dmem_req_q    <= 1'b0;
         dmem_we_q     <= 1'b0;
         wb_sel_q      <= WB_ALU;
         fetch_en_q    <= 1'b0;
         regfetch_en_q <= 1'b0;
         execute_en_q  <= 1'b0;
         pc_en_q       <= 1'b0;
         pc_branch_q   <= 1'b0;
         cpsr_write_q  <= 1'b0;
         reg_write_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_q        <= wait_d;
         fault_q       <= fault_d;
         retired_q     <= retired_d;
         imem_req_q    <= imem_req_d;
         dmem_req_q    <= dmem_req_d;
         dmem_we_q     <= dmem_we_d;
         wb_sel_q      <= wb_sel_d;
         fetch_en_q    <= fetch_en_d;
         regfetch_en_q <= regfetch_en_d;
         execute_en_q  <= execute_en_d;
         pc_en_q       <= pc_en_d;
         pc_branch_q   <= pc_branch_d;
         cpsr_write_q  <= cpsr_write_d;
         reg_write_q   <= reg_write_d;
      end
   end

   assign bus.state       = state_q;
   assign bus.fault       = fault_q;
   assign bus.retired     = retired_q;
   assign bus.imem_req    = imem_req_q;
   assign bus.dmem_req    = dmem_req_q;
   assign bus.dmem_we     = dmem_we_q;
   assign bus.wb_sel      = wb_sel_q;
   assign bus.fetch_en    = fetch_en_q;
   assign bus.regfetch_en = regfetch_en_q;
   assign bus.execute_en  = execute_en_q;
   assign bus.pc_en       = pc_en_q;
   assign bus.pc_branch   = pc_branch_q;
   assign bus.cpsr_write  = cpsr_write_q;
   assign bus.reg_write   = reg_write_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction expected traces built from the
// instruction-class rules, compared against the DUT after every clock edge.
module tb_multicycle_controller;

   localparam int unsigned TB_CNT_W = 4;
   localparam int unsigned TMO      = 15;

   typedef struct packed {
      logic [2:0]          state;
      logic                imem_req;
      logic                dmem_req;
      logic                dmem_we;
      logic                fetch_en;
      logic                regfetch_en;
      logic                execute_en;
      logic                pc_en;
      logic                pc_branch;
      logic                cpsr_write;
      logic                reg_write;
      logic [1:0]          wb_sel;
      logic                fault;
      logic [TB_CNT_W-1:0] retired;
   } obs_t;

   logic clk;
   logic nreset;
   obs_t exp_o;
   int   n_checks, n_pass;
   int   n_cyc, n_cpsr, n_branch, n_dreq, n_regw;
   bit   stall_en;

   multicycle_controller_if #(.CNT_W(TB_CNT_W)) bus ();

   multicycle_controller #(.MEM_TIMEOUT(TMO), .CNT_W(TB_CNT_W)) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic obs_t sample();
      obs_t s;
      s.state = bus.state;           s.imem_req = bus.imem_req;
      s.dmem_req = bus.dmem_req;     s.dmem_we = bus.dmem_we;
      s.fetch_en = bus.fetch_en;     s.regfetch_en = bus.regfetch_en;
      s.execute_en = bus.execute_en; s.pc_en = bus.pc_en;
      s.pc_branch = bus.pc_branch;   s.cpsr_write = bus.cpsr_write;
      s.reg_write = bus.reg_write;   s.wb_sel = bus.wb_sel;
      s.fault = bus.fault;           s.retired = bus.retired;
      return s;
   endfunction

   // Same persistent values as c with every one-cycle strobe cleared.
   function automatic obs_t quiet(input obs_t c);
      obs_t r;
      r = c;
      r.fetch_en = 1'b0; r.regfetch_en = 1'b0; r.execute_en = 1'b0; r.pc_en = 1'b0;
      r.pc_branch = 1'b0; r.cpsr_write = 1'b0; r.reg_write = 1'b0;
      return r;
   endfunction

   // Advance one clock with inputs already driven; compare outputs just after the edge.
   task automatic cyc(input obs_t e);
      obs_t a, x;
      @(posedge clk);
      #1;
      a = sample();
      x = e;
      if (!x.dmem_req)  begin a.dmem_we = 1'b0; x.dmem_we = 1'b0; end
      if (!x.reg_write) begin a.wb_sel = 2'd0;  x.wb_sel = 2'd0;  end
      n_checks++;
      if (a === x) n_pass++;
      else $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, a, x);
      n_cyc++;
      if (a.cpsr_write) n_cpsr++;
      if (a.pc_branch)  n_branch++;
      if (a.dmem_req)   n_dreq++;
      if (a.reg_write)  n_regw++;
      exp_o = e;
      @(negedge clk);
   endtask

   task automatic check_lit(input string name, input int act, input int want);
      n_checks++;
      if (act == want) n_pass++;
      else $display("FAIL %s got=%0d want=%0d", name, act, want);
   endtask

   // Random stall bursts; ready/cond toggle meanwhile and must be ignored.
   task automatic stalls();
      int n;
      n = (stall_en && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      for (int i = 0; i < n; i++) begin
         bus.stall      = 1'b1;
         bus.imem_ready = 1'($urandom_range(0, 1));
         bus.dmem_ready = 1'($urandom_range(0, 1));
         bus.cond_pass  = 1'($urandom_range(0, 1));
         cyc(quiet(exp_o));
      end
      bus.stall = 1'b0; bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
   endtask

   // delay unanswered cycles; ok=0 when the timeout fired instead.
   task automatic await_ready(input int delay, output bit ok);
      obs_t e;
      ok = 1'b1;
      for (int w = 1; w <= delay; w++) begin
         stalls();
         e = quiet(exp_o);
         if (w == int'(TMO)) begin
            e.fault = 1'b1; e.pc_en = 1'b1; e.state = 3'd0;
            e.imem_req = 1'b0; e.dmem_req = 1'b0;
            cyc(e);
            ok = 1'b0;
            return;
         end
         cyc(e);
      end
      stalls();
   endtask

   task automatic do_instr(input logic [31:0] ins, input bit cp, input int idly,
                           input int ddly, input bit rst_mem);
      obs_t e;
      bit   ok;
      int   f, opc;
      bit   s_bit, lnk;
      f     = int'((ins >> 25) & 32'd7);
      opc   = int'((ins >> 21) & 32'd15);
      s_bit = ins[20];
      lnk   = ins[24];
      bus.instr = ins;
      if (!exp_o.imem_req) begin
         stalls();
         e = quiet(exp_o); e.imem_req = 1'b1;
         cyc(e);
      end
      await_ready(idly, ok);
      if (!ok) return;
      bus.imem_ready = 1'b1;
      e = quiet(exp_o); e.fetch_en = 1'b1; e.imem_req = 1'b0; e.state = 3'd1;
      cyc(e);
      bus.imem_ready = 1'b0;
      stalls();
      e = quiet(exp_o); e.regfetch_en = 1'b1; e.state = 3'd2;
      cyc(e);
      stalls();
      bus.cond_pass = cp;
      e = quiet(exp_o); e.execute_en = 1'b1;
      if (!cp || f == 4 || f >= 6) begin
         e.pc_en = 1'b1; e.retired = e.retired + TB_CNT_W'(1); e.state = 3'd0; e.imem_req = 1'b1;
      end else if (f < 2) begin
         e.cpsr_write = s_bit;
         if (s_bit && opc >= 8 && opc <= 11) begin
            e.pc_en = 1'b1; e.retired = e.retired + TB_CNT_W'(1); e.state = 3'd0; e.imem_req = 1'b1;
         end else begin
            e.wb_sel = 2'd0; e.state = 3'd4;
         end
      end else if (f == 5) begin
         e.pc_en = 1'b1; e.pc_branch = 1'b1;
         if (lnk) begin
            e.wb_sel = 2'd2; e.state = 3'd4;
         end else begin
            e.retired = e.retired + TB_CNT_W'(1); e.state = 3'd0; e.imem_req = 1'b1;
         end
      end else begin
         e.state = 3'd3; e.dmem_req = 1'b1; e.dmem_we = ~s_bit;
      end
      cyc(e);
      if (e.state == 3'd3) begin
         if (rst_mem) begin
            bus.dmem_ready = 1'b0;
            cyc(quiet(exp_o));
            nreset = 1'b1;
            cyc('0);
            nreset = 1'b0;
            return;
         end
         await_ready(ddly, ok);
         if (!ok) return;
         bus.dmem_ready = 1'b1;
         e = quiet(exp_o); e.dmem_req = 1'b0;
         if (s_bit) begin
            e.wb_sel = 2'd1; e.state = 3'd4;
         end else begin
            e.pc_en = 1'b1; e.retired = e.retired + TB_CNT_W'(1); e.state = 3'd0; e.imem_req = 1'b1;
         end
         cyc(e);
         bus.dmem_ready = 1'b0;
      end
      if (e.state == 3'd4) begin
         stalls();
         e = quiet(exp_o);
         e.reg_write = 1'b1; e.pc_en = (f != 5); e.retired = e.retired + TB_CNT_W'(1);
         e.state = 3'd0; e.imem_req = 1'b1;
         cyc(e);
      end
   endtask

   initial begin
      int c0, r0;
      logic [31:0] ins;
      n_checks = 0; n_pass = 0; n_cyc = 0;
      n_cpsr = 0; n_branch = 0; n_dreq = 0; n_regw = 0;
      stall_en = 1'b0;
      bus.stall = 1'b0; bus.instr = '0; bus.cond_pass = 1'b0;
      bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
      nreset = 1'b1;
      cyc('0);
      cyc('0);
      nreset = 1'b0;
      check_lit("reset_state", int'(bus.state), 0);
      check_lit("reset_retired", int'(bus.retired), 0);
      check_lit("reset_imem_req", int'(bus.imem_req), 0);

      // ADD r1,r2,r3
      r0 = n_regw;
      do_instr(32'hE0821003, 1'b1, 0, 0, 1'b0);
      check_lit("add_retired", int'(bus.retired), 1);
      check_lit("add_reg_writes", n_regw - r0, 1);
      // CMP r1,#0: fetch, decode, execute only
      c0 = n_cyc; r0 = n_cpsr;
      do_instr(32'hE3510000, 1'b1, 0, 0, 1'b0);
      check_lit("cmp_cycles", n_cyc - c0, 3);
      check_lit("cmp_cpsr_writes", n_cpsr - r0, 1);
      // BL
      r0 = n_branch;
      do_instr(32'hEB000004, 1'b1, 0, 0, 1'b0);
      check_lit("bl_branches", n_branch - r0, 1);
      // LDR with three-cycle data latency
      r0 = n_dreq;
      do_instr(32'hE5921000, 1'b1, 0, 3, 1'b0);
      check_lit("ldr_dmem_req_cycles", n_dreq - r0, 4);
      // STR: no register write
      r0 = n_regw;
      do_instr(32'hE5821000, 1'b1, 0, 1, 1'b0);
      check_lit("str_reg_writes", n_regw - r0, 0);
      // ADDNE, condition failed
      r0 = n_regw;
      do_instr(32'h10821003, 1'b0, 0, 0, 1'b0);
      check_lit("addne_retired", int'(bus.retired), 6);
      check_lit("addne_reg_writes", n_regw - r0, 0);
      // instruction fetch never answered
      do_instr(32'hE0821003, 1'b1, 100, 0, 1'b0);
      check_lit("timeout_fault", int'(bus.fault), 1);
      check_lit("timeout_retired", int'(bus.retired), 6);
      // reset while a load waits in MEMORY
      do_instr(32'hE5921000, 1'b1, 0, 5, 1'b1);
      check_lit("rst_fault", int'(bus.fault), 0);
      check_lit("rst_dmem_req", int'(bus.dmem_req), 0);
      check_lit("rst_retired", int'(bus.retired), 0);

      // randomized instruction stream with stalls and latencies
      stall_en = 1'b1;
      for (int i = 0; i < 80; i++) begin
         ins = $urandom;
         do_instr(ins, 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 19) == 0) ? 40 : int'($urandom_range(0, 3)),
                  ($urandom_range(0, 19) == 0) ? 40 : int'($urandom_range(0, 3)),
                  1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
